// File: rtl/cam_frame_ctrl.sv
// Frame-capture controller: waits for frame start, forwards N whole frames from a
// free-running raster camera through a small pixel FIFO, and flags overflow.
module cam_frame_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int HW = $clog2(IMG_WIDTH),
  localparam int VW = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  start_i,
  input  logic [7:0]            num_frames_i,
  input  logic                  abort_i,
  input  logic [HW-1:0]         cam_hcount_i,
  input  logic [VW-1:0]         cam_vcount_i,
  input  logic [DATA_WIDTH-1:0] cam_din_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_sof_o,
  output logic                  m_eol_o,
  output logic                  m_eof_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [7:0]            frames_done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                  eof;
    logic                  eol;
    logic                  sof;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN} state_t;

  state_t          state_q;
  ent_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      num_q, fd_q, fd_inc;
  logic            ovf_q, busy_q, done_q;
  logic            pix_sof, pix_eol, pix_eof;
  logic            rd, wr_req, wr_ok, wr_en;
  ent_t            head, wr_ent;

  assign pix_sof = (cam_hcount_i == '0) && (cam_vcount_i == '0);
  assign pix_eol = cam_hcount_i == HW'(IMG_WIDTH-1);
  assign pix_eof = pix_eol && (cam_vcount_i == VW'(IMG_HEIGHT-1));
  assign wr_ent  = '{eof: pix_eof, eol: pix_eol, sof: pix_sof, data: cam_din_i};

  // A full FIFO may still take a pixel when the head leaves in the same cycle.
  assign rd     = (cnt_q != '0) && m_ready_i;
  assign wr_ok  = (cnt_q < DEPTH_C) || rd;
  assign wr_req = !abort_i && ((state_q == WAIT_SOF && pix_sof) || state_q == CAPTURE);
  assign wr_en  = wr_req && wr_ok;
  assign fd_inc = fd_q + 8'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !rd)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && rd) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wp_q] <= wr_ent;
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + AW'(1);
      if (rd)    rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      num_q   <= '0;
      fd_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i && num_frames_i != 8'd0) begin
          num_q   <= num_frames_i;
          fd_q    <= '0;
          ovf_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= WAIT_SOF;
        end
        WAIT_SOF, CAPTURE: begin
          if (abort_i) state_q <= DRAIN;
          else if (wr_req) begin
            // A dropped pixel ends the capture; the consumer sees a truncated frame.
            if (!wr_ok) begin
              ovf_q   <= 1'b1;
              state_q <= DRAIN;
            end else begin
              state_q <= CAPTURE;
              if (pix_eof) begin
                fd_q <= fd_inc;
                if (fd_inc == num_q) state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: if (cnt_q == '0) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign head          = mem_q[rp_q];
  assign m_valid_o     = cnt_q != '0;
  assign m_data_o      = m_valid_o ? head.data : '0;
  assign m_sof_o       = m_valid_o & head.sof;
  assign m_eol_o       = m_valid_o & head.eol;
  assign m_eof_o       = m_valid_o & head.eof;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;
  assign frames_done_o = fd_q;
endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed bench for cam_frame_ctrl on an 8x4 raster camera model.
module tb_cam_frame_ctrl;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_frames = 8'd0;
  logic       abort = 1'b0;
  logic       m_ready = 1'b1;
  logic [2:0] h = 3'd0;
  logic [1:0] v = 2'd0;
  logic [7:0] din;
  logic [7:0] m_data, frames_done;
  logic       m_valid, m_sof, m_eol, m_eof, busy, done, overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nbeats = 0;
  int ndone  = 0;
  int dbusy  = 0;
  logic [10:0] bt [1024];
  int          bc [1024];

  always #5 clk = ~clk;

  // Free-running camera: pixel value encodes its own position.
  always @(posedge clk) begin
    if (h == 3'd7) begin h <= 3'd0; v <= v + 2'd1; end
    else h <= h + 3'd1;
  end
  assign din = {3'b000, v, h};

  cam_frame_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .num_frames_i(num_frames),
    .abort_i(abort), .cam_hcount_i(h), .cam_vcount_i(v), .cam_din_i(din),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_sof_o(m_sof), .m_eol_o(m_eol), .m_eof_o(m_eof), .busy_o(busy),
    .done_o(done), .overflow_o(overflow), .frames_done_o(frames_done));

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (n_rst && m_valid && m_ready) begin
      bt[nbeats % 1024] <= {m_eof, m_eol, m_sof, m_data};
      bc[nbeats % 1024] <= cyc;
      nbeats <= nbeats + 1;
    end
    if (done) ndone <= ndone + 1;
    if (done && busy) dbusy <= dbusy + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input logic [2:0] hh, input logic [1:0] vv);
    int k = 0;
    while (!(h == hh && v == vv) && k < 64) begin tick(); k++; end
    chk("cam_pos_reached", {31'd0, (h == hh && v == vv)}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!m_valid && k < 100) begin tick(); k++; end
    chk({tag, "_valid_seen"}, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = ndone;
    int k = 0;
    while (ndone == n0 && k < budget) begin tick(); k++; end
    chk({tag, "_done_seen"}, ndone - n0, 32'd1);
  endtask

  // Beat i of a capture is raster pixel i%32 of a frame that starts at (0,0).
  task automatic chk_stream(input string tag, input int base, input int n_exp, input bit contig);
    int n = nbeats - base;
    int err = 0;
    chk({tag, "_beats"}, n, n_exp);
    for (int i = 0; i < n && i < n_exp; i++) begin
      int p = i % 32;
      logic [10:0] e;
      e = {(p == 31), (p % 8 == 7), (p == 0), 8'(p)};
      if (bt[(base + i) % 1024] !== e) err++;
    end
    chk({tag, "_flags_data"}, err, 0);
    if (contig && n == n_exp && n > 0)
      chk({tag, "_span"}, bc[(base + n - 1) % 1024] - bc[base % 1024], n_exp - 1);
  endtask

  task automatic do_start(input logic [7:0] nf);
    start = 1'b1; num_frames = nf;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int b, d0;
    // 1. reset
    repeat (3) tick();
    n_rst = 1'b1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frames_done, 0);
    repeat (5) tick();
    chk("idle_busy", busy, 0);

    // 2. single frame, start mid-frame
    wait_pos(3'd3, 2'd1);
    b = nbeats; d0 = ndone;
    do_start(8'd1);
    chk("t2_busy", busy, 1);
    chk("t2_no_early", m_valid, 0);
    wait_done("t2", 200);
    repeat (3) tick();
    chk_stream("t2", b, 32, 1'b1);
    chk("t2_ndone", ndone - d0, 1);
    chk("t2_fd", frames_done, 1);
    chk("t2_ovf", overflow, 0);
    chk("t2_busy_end", busy, 0);

    // 3. three contiguous frames
    b = nbeats; d0 = ndone;
    do_start(8'd3);
    wait_done("t3", 300);
    repeat (3) tick();
    chk_stream("t3", b, 96, 1'b1);
    chk("t3_ndone", ndone - d0, 1);
    chk("t3_fd", frames_done, 3);

    // 4. backpressure overflow
    m_ready = 1'b0;
    b = nbeats;
    do_start(8'd1);
    wait_valid("t4");
    repeat (19) tick();
    chk("t4_ovf", overflow, 1);
    chk("t4_busy_full", busy, 1);
    m_ready = 1'b1;
    wait_done("t4", 100);
    chk_stream("t4", b, 16, 1'b1);
    chk("t4_busy_end", busy, 0);
    chk("t4_fd", frames_done, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // 5b. abort in WAIT_SOF (also: new start clears overflow)
    wait_pos(3'd3, 2'd1);
    b = nbeats;
    do_start(8'd1);
    chk("t5b_ovf_clr", overflow, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5b_done_early", done, 0);
    tick();
    chk("t5b_done", done, 1);
    chk("t5b_busy", busy, 0);
    tick();
    chk("t5b_beats", nbeats - b, 0);

    // 5a. abort at 10th capture cycle (SOF pixel is cycle 1)
    b = nbeats; d0 = ndone;
    do_start(8'd1);
    wait_pos(3'd0, 2'd0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t5a", 50);
    chk_stream("t5a", b, 9, 1'b1);
    chk("t5a_fd", frames_done, 0);
    chk("t5a_ndone", ndone - d0, 1);

    // 6. ignored requests
    do_start(8'd0);
    chk("t6_zero_busy", busy, 0);
    repeat (3) tick();
    chk("t6_zero_busy2", busy, 0);
    b = nbeats;
    do_start(8'd2);
    wait_valid("t6");
    do_start(8'd5);
    wait_done("t6", 300);
    repeat (3) tick();
    chk_stream("t6", b, 64, 1'b1);
    chk("t6_fd", frames_done, 2);

    // reset mid-capture: flush without done
    do_start(8'd1);
    wait_valid("rstm");
    d0 = ndone;
    n_rst = 1'b0;
    tick();
    chk("rstm_valid", m_valid, 0);
    chk("rstm_busy", busy, 0);
    n_rst = 1'b1;
    repeat (3) tick();
    chk("rstm_nodone", ndone - d0, 0);
    chk("rstm_idle_valid", m_valid, 0);

    chk("done_busy_overlap", dbusy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
